// File: rtl/ofd_cmd_pkg.sv
// ----------------------------------------------------------------------------
// ofd_cmd_pkg
// Shared definitions for the host command frame decoder:
//   cmd_state_t   - frame parser states (SYNC, CMD, ARG_H, ARG_L, CHK)
//   SYNC_BYTE_DEF - default frame start marker
//   CMD_START_DEF - default command code that fires trig_start
//   FRAME_LEN     - bytes per frame, including SYNC and CHK
//   frame_chk()   - 8-bit XOR checksum over CMD, ARG_H and ARG_L
// ----------------------------------------------------------------------------
package ofd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_ARGH,
        ST_GET_ARGL,
        ST_GET_CHK
    } cmd_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0]  CMD_START_DEF = 8'h01;
    localparam int unsigned FRAME_LEN     = 5;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] ah,
                                             input logic [7:0] al);
        return cmd ^ ah ^ al;
    endfunction

endpackage

// File: rtl/ofd_timeout_cnt.sv
// ----------------------------------------------------------------------------
// ofd_timeout_cnt
// Inter-byte timeout counter with a parameterised terminal count.
//   clk, reset : clock, synchronous active-high reset
//   clear      : forces the count to zero (has priority over run)
//   run        : counts up by one per cycle
//   expired    : combinational; high while running with the count at
//                TERMINAL-1, i.e. the coming edge is the timeout edge
// ----------------------------------------------------------------------------
module ofd_timeout_cnt #(
    parameter int unsigned TERMINAL = 17360,
    parameter int unsigned CNT_W    = $clog2(TERMINAL + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = run && (cnt_q == LAST);

    // Holds at LAST rather than wrapping; the parent returns to idle on
    // expiry, which clears the count on the following cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ----------------------------------------------------------------------------
// uart_cmd_decoder
// Parses 5-byte host frames (SYNC, CMD, ARG_H, ARG_L, CHK) from the uart
// receive strobe and emits validated commands.
//   clk, reset  : clock, synchronous active-high reset
//   rx_data     : received byte, valid while rx_ready=1
//   rx_ready    : one-cycle strobe per received byte
//   cmd_valid   : one-cycle pulse, frame accepted
//   cmd_code    : CMD byte of last accepted frame
//   cmd_arg     : {ARG_H, ARG_L} of last accepted frame
//   trig_start  : one-cycle pulse with cmd_valid when cmd_code==CMD_START
//   frame_err   : one-cycle pulse on checksum error or inter-byte timeout
//   err_count   : saturating count of frame_err pulses
//   busy        : combinational, high while a frame is partially received
// ----------------------------------------------------------------------------
module uart_cmd_decoder
    import ofd_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [7:0]  CMD_START      = CMD_START_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 17360,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_arg,
    output logic        trig_start,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    cmd_state_t  state_q,      state_d;
    logic [7:0]  cmd_q,        cmd_d;
    logic [7:0]  arg_h_q,      arg_h_d;
    logic [7:0]  arg_l_q,      arg_l_d;
    logic        cmd_valid_q,  cmd_valid_d;
    logic        trig_q,       trig_d;
    logic        frame_err_q,  frame_err_d;
    logic [7:0]  err_count_q,  err_count_d;
    logic [7:0]  cmd_code_q,   cmd_code_d;
    logic [15:0] cmd_arg_q,    cmd_arg_d;

    logic        tmo_clear;
    logic        tmo_run;
    logic        tmo_expired;

    assign busy = (state_q != ST_IDLE);

    // Every byte seen outside IDLE is accepted, so any strobe restarts the
    // inter-byte window; a strobe on the limit cycle therefore suppresses
    // expiry because run is low.
    assign tmo_clear = !busy || rx_ready;
    assign tmo_run   = busy && !rx_ready;

    ofd_timeout_cnt #(
        .TERMINAL (TIMEOUT_CYCLES),
        .CNT_W    (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .run     (tmo_run),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        arg_h_d     = arg_h_q;
        arg_l_d     = arg_l_q;
        cmd_code_d  = cmd_code_q;
        cmd_arg_d   = cmd_arg_q;
        err_count_d = err_count_q;
        cmd_valid_d = 1'b0;
        trig_d      = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_ready && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_GET_CMD;
                end
            end
            ST_GET_CMD: begin
                if (rx_ready) begin
                    cmd_d   = rx_data;
                    state_d = ST_GET_ARGH;
                end
            end
            ST_GET_ARGH: begin
                if (rx_ready) begin
                    arg_h_d = rx_data;
                    state_d = ST_GET_ARGL;
                end
            end
            ST_GET_ARGL: begin
                if (rx_ready) begin
                    arg_l_d = rx_data;
                    state_d = ST_GET_CHK;
                end
            end
            ST_GET_CHK: begin
                if (rx_ready) begin
                    state_d = ST_IDLE;
                    if (rx_data == frame_chk(cmd_q, arg_h_q, arg_l_q)) begin
                        cmd_valid_d = 1'b1;
                        trig_d      = (cmd_q == CMD_START);
                        cmd_code_d  = cmd_q;
                        cmd_arg_d   = {arg_h_q, arg_l_q};
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry only fires with rx_ready low, so it never races a byte above.
        if (tmo_expired) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end

        if (frame_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            arg_h_q     <= '0;
            arg_l_q     <= '0;
            cmd_valid_q <= 1'b0;
            trig_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
            cmd_code_q  <= '0;
            cmd_arg_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            arg_h_q     <= arg_h_d;
            arg_l_q     <= arg_l_d;
            cmd_valid_q <= cmd_valid_d;
            trig_q      <= trig_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign trig_start = trig_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;
    assign cmd_code   = cmd_code_q;
    assign cmd_arg    = cmd_arg_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Self-checking bench for uart_cmd_decoder: table of frames plus hand-written
// timeout, limit-cycle, reset and saturation sequences. Expected output
// events are queued when a frame is driven and compared when a pulse shows.
// ----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

    localparam int unsigned T = 17360;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_arg;
    logic        trig_start;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_arg    (cmd_arg),
        .trig_start (trig_start),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] bytes;
        int          gap;
        bit          ok;
        bit          trig;
        logic [7:0]  code;
        logic [15:0] arg;
    } vec_t;

    typedef struct {
        bit          ok;
        bit          trig;
        logic [7:0]  code;
        logic [15:0] arg;
        logic [7:0]  errcnt;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  m_code = 8'h00;
    logic [15:0] m_arg  = 16'h0000;
    logic [7:0]  m_err  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_expect(input bit ok, input bit trig, input logic [7:0] code,
                               input logic [15:0] arg);
        exp_t e;
        if (ok) begin
            m_code = code;
            m_arg  = arg;
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
        e.ok = ok; e.trig = trig; e.code = m_code; e.arg = m_arg; e.errcnt = m_err;
        sb.push_back(e);
    endtask

    // Called just after a falling edge; holds the strobe across one rising edge.
    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v, input string name);
        logic [39:0] fb;
        fb = v.bytes;
        push_expect(v.ok, v.trig, v.code, v.arg);
        for (int k = 0; k < 5; k++) begin
            drive(fb[39-8*k -: 8]);
            if (k == 4) begin
                #1;
                check({name, "_latency"}, sb.size(), 0);
            end
            idle(v.gap);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (cmd_valid || frame_err || trig_start)) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", {29'd0, cmd_valid, trig_start, frame_err}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cmd_valid", cmd_valid, e.ok);
                check("frame_err", frame_err, !e.ok);
                check("trig_start", trig_start, e.trig);
                check("cmd_code", cmd_code, e.code);
                check("cmd_arg", cmd_arg, e.arg);
                check("err_count", err_count, e.errcnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs [4];
    vec_t start_v;

    initial begin
        vecs[0] = '{bytes: 40'hA5_01_12_34_27, gap: 1, ok: 1, trig: 1, code: 8'h01, arg: 16'h1234};
        vecs[1] = '{bytes: 40'hA5_05_00_FF_FA, gap: 1, ok: 1, trig: 0, code: 8'h05, arg: 16'h00FF};
        vecs[2] = '{bytes: 40'hA5_01_12_34_00, gap: 0, ok: 0, trig: 0, code: 8'h00, arg: 16'h0000};
        vecs[3] = '{bytes: 40'hA5_01_12_34_27, gap: 0, ok: 1, trig: 1, code: 8'h01, arg: 16'h1234};
        start_v = vecs[0];

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_trig", trig_start, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_cmd_arg", cmd_arg, 0);
        check("rst_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end
        check("table_err_count", err_count, m_err);

        // Timeout after A5 01; expiry must land exactly T cycles after the last byte.
        push_expect(0, 0, 8'h00, 16'h0000);
        drive(8'hA5);
        drive(8'h01);
        check("tmo_busy_start", busy, 1);
        idle(T - 1);
        #1;
        check("tmo_not_early_busy", busy, 1);
        check("tmo_not_early_sb", sb.size(), 1);
        @(negedge clk);
        #1;
        check("tmo_busy_fall", busy, 0);
        check("tmo_pulse_seen", sb.size(), 0);
        idle(2);
        run_frame(start_v, "after_tmo");

        // IDLE noise, then a byte landing on the limit cycle.
        drive(8'h00);
        drive(8'hFF);
        drive(8'h13);
        idle(1);
        check("noise_busy", busy, 0);
        push_expect(1, 0, 8'h02, 16'hAA55);
        drive(8'hA5);
        drive(8'h02);
        drive(8'hAA);
        idle(T - 1);
        drive(8'h55);
        drive(8'hFD);
        #1;
        check("limit_sb", sb.size(), 0);
        check("limit_err_count", err_count, m_err);
        check("limit_busy", busy, 0);
        idle(2);

        // Reset mid-frame: partial frame dropped silently, registers cleared.
        drive(8'hA5);
        drive(8'h01);
        drive(8'h12);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_frame_err", frame_err, 0);
        reset = 1'b0;
        m_code = 8'h00;
        m_arg  = 16'h0000;
        m_err  = 8'h00;
        @(negedge clk);
        check("postrst_frame_err", frame_err, 0);
        check("postrst_err_count", err_count, 0);
        check("postrst_cmd_code", cmd_code, 0);
        run_frame(start_v, "after_rst");

        // 256 bad-checksum frames back to back: counter must pin at FF.
        for (int n = 0; n < 256; n++) begin
            push_expect(0, 0, 8'h00, 16'h0000);
            drive(8'hA5);
            drive(8'h00);
            drive(8'h00);
            drive(8'h00);
            drive(8'h01);
        end
        #1;
        check("sat_sb", sb.size(), 0);
        check("sat_err_count", err_count, 8'hFF);
        idle(3);
        check("sat_hold", err_count, 8'hFF);
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
